// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - general-purpose register file with write bypass and busy scoreboard
//
// Two combinational read ports, one write port, same-cycle write-to-read
// bypass and a per-register busy scoreboard for multi-cycle producers.
// After reset a sweep engine clears one entry per edge so the storage array
// needs no reset and can map onto RAM.
//
// Optional feature macro: GPR_TRACE_EN (prints write/reservation trace lines)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   ready     out  clear sweep finished, file accepts traffic
//   ra1/ra2   in   read addresses
//   rd1/rd2   out  read data (combinational, bypassed)
//   busy1/2   out  scoreboard bit for ra1/ra2
//   we/wa/wd  in   write port
//   rsv_en    in   reserve request, marks rsv_addr busy
//   rsv_addr  in   register being reserved

module gpr_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  output logic              busy1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic run;
  logic eff_we;
  logic eff_rsv;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign run   = (state == ST_RUN);
  assign ready = run;

  // Reset has priority over any update sampled at the same edge.
  assign eff_we  = run && !reset && we     && !is_zero_reg(wa);
  assign eff_rsv = run && !reset && rsv_en && !is_zero_reg(rsv_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    if (state == ST_CLEAR) begin
      clr_ptr_next = clr_ptr + 1'b1;
      if (clr_ptr == LAST_IDX) begin
        state_next = ST_RUN;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR && !reset) begin
      mem[clr_ptr] <= '0;
    end else if (eff_we) begin
      mem[wa] <= wd;
    end
  end

  // Reservation is applied after the write clear so a same-address
  // collision leaves the register busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (run) begin
      if (eff_we) begin
        busy[wa] <= 1'b0;
      end
      if (eff_rsv) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // A bypassed read is never busy: the producer's result is on wd now.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (run && !is_zero_reg(ra1)) begin
      if (eff_we && wa == ra1) begin
        rd1 = wd;
      end else begin
        rd1   = mem[ra1];
        busy1 = busy[ra1];
      end
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (run && !is_zero_reg(ra2)) begin
      if (eff_we && wa == ra2) begin
        rd2 = wd;
      end else begin
        rd2   = mem[ra2];
        busy2 = busy[ra2];
      end
    end
  end

`ifdef GPR_TRACE_EN
  always_ff @(posedge clk) begin
    if (eff_we) begin
      $display("$%0d <= %h", wa, wd);
    end
    if (eff_rsv) begin
      $display("rsv $%0d", rsv_addr);
    end
  end
`endif

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU core: two combinational read ports, one write port, same-cycle write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers (mult/div, loads). Reset clears storage with a sweep engine, one entry per cycle, so large files can map to RAM. Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes and reservations to 0 ignored); 0 = entry 0 is ordinary

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
ready  out  1  high when clear sweep is done and file accepts traffic
ra1  in  ADDR_W  read address, port 1
rd1  out  DATA_W  read data, port 1
busy1  out  1  scoreboard bit for ra1
ra2  in  ADDR_W  read address, port 2
rd2  out  DATA_W  read data, port 2
busy2  out  1  scoreboard bit for ra2
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
rsv_en  in  1  reserve request: mark rsv_addr busy
rsv_addr  in  ADDR_W  register being reserved

Behaviour:
- Reset: reset sampled high -> state CLEAR, clr_ptr=0, all busy bits 0, ready=0 next edge. Applies from any state, including mid-sweep (sweep restarts at 0).
- CLEAR: each edge with reset low writes mem[clr_ptr]=0, clr_ptr++. After edge writing entry DEPTH-1 -> state RUN, ready=1. ready rises exactly DEPTH edges after first edge with reset low (DEPTH=32 -> 32 edges).
- During CLEAR: we and rsv_en ignored; rd1/rd2 = 0; busy1/busy2 = 0.
- RUN write: at edge, if we=1 and not (ZERO_REG=1 and wa=0) -> mem[wa]=wd.
- Read: combinational. Priority: (a) ZERO_REG=1 and ra=0 -> 0; (b) effective write (as above) with wa=ra -> wd (bypass); (c) mem[ra].
- Scoreboard, per edge in RUN: effective write clears busy[wa]; rsv_en=1 sets busy[rsv_addr] (ignored if ZERO_REG=1 and rsv_addr=0). Same address both in one cycle -> set wins (busy=1 after edge).
- busyN combinational: busy[raN], forced 0 when effective write to raN in same cycle (result is bypassed); forced 0 for ra=0 when ZERO_REG=1.
- Both read ports may hit same address; both return identical data/busy.
- Write with we=1 to an unreserved register permitted; busy stays 0.

Optional Feature:
GPR_TRACE_EN: when defined, every effective write prints simulation trace "$<wa> <= <wd hex>" and every reservation prints "rsv $<addr>"; writes/reservations suppressed for zero register print nothing. Without it: no $display, identical RTL behaviour.

Test Plan:
- reset high 3 cycles, release -> ready=0 for 32 edges, 1 after 32nd; rd1 for ra1=7 reads 0 throughout.
- RUN: we=1 wa=5 wd=0xDEADBEEF, ra1=5 same cycle -> rd1=0xDEADBEEF combinationally; next cycle with we=0 still 0xDEADBEEF.
- ZERO_REG=1: we=1 wa=0 wd=0x12345678, rsv_en=1 rsv_addr=0 -> rd1(ra1=0)=0, busy1=0.
- rsv_en rsv_addr=9 -> busy2(ra2=9)=1 next cycle; later we wa=9 wd=0x55 -> busy2=0 in write cycle, rd2=0x55; after edge busy2=0.
- Same cycle rsv_en rsv_addr=3 and we wa=3 wd=0x1 -> after edge busy[3]=1, mem[3]=0x1.
- Reset asserted mid-sweep (edge 10 of CLEAR) and mid-RUN with busy[4]=1 -> ready=0, busy all 0, sweep restarts, all reads 0 after ready returns 32 edges post-release.
